// File: rtl/split_issue_13bit.sv
`timescale 1ns/1ps
// split_issue_13bit
// Front end of the 13-bit GF(2) Karatsuba stage. Captures one pair of 13-bit
// operands, splits each at bit 7 into a 7-bit low half and a zero-extended
// 6-bit high half, and issues three 7-bit sub-operand pairs in fixed order:
// low (tag 0), middle = lo ^ hi (tag 1), high (tag 2, out_last).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand pair handshake (in_ready is combinational)
//   A_in, B_in          13-bit operands, bit i = coefficient of x^i
//   out_valid/out_ready sub-operand pair handshake
//   A_out, B_out        7-bit sub-operands (registered)
//   out_tag, out_last   slot of the pair, last flag for the high slot
//   op_count            fully issued operand pairs, wraps modulo 2^16
module split_issue_13bit #(
  parameter int unsigned N    = 14,
  parameter int unsigned LO_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-2:0]    A_in,
  input  logic [N-2:0]    B_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LO_W-1:0] A_out,
  output logic [LO_W-1:0] B_out,
  output logic [1:0]      out_tag,
  output logic            out_last,
  output logic [15:0]     op_count
);

  localparam int unsigned OP_W  = N - 1;
  localparam int unsigned HI_W  = OP_W - LO_W;
  localparam int unsigned TAG_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE_LO  = 2'd1,
    S_ISSUE_MID = 2'd2,
    S_ISSUE_HI  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [OP_W-1:0]  a_hold_q, b_hold_q;
  logic             out_valid_q, out_valid_d;
  logic [LO_W-1:0]  a_out_q, a_out_d;
  logic [LO_W-1:0]  b_out_q, b_out_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] op_count_q;

  logic             accept;
  logic             issue_done;
  logic [OP_W-1:0]  a_src, b_src;

  // Low half of an operand.
  function automatic logic [LO_W-1:0] lo_half(input logic [OP_W-1:0] x);
    return x[LO_W-1:0];
  endfunction

  // High half of an operand, zero-extended to the sub-operand width.
  function automatic logic [LO_W-1:0] hi_half(input logic [OP_W-1:0] x);
    return LO_W'(x[LO_W +: HI_W]);
  endfunction

  // Ready in IDLE, or during the high-slot handoff so a new pair can enter
  // without a bubble.
  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_ISSUE_HI) && out_ready);
  assign accept     = in_valid && in_ready;
  assign issue_done = (state_q == S_ISSUE_HI) && out_ready;

  // On an accept the holding registers are loaded on the same edge as the
  // low-slot outputs, so the low slot has to be taken from the inputs.
  assign a_src = accept ? A_in : a_hold_q;
  assign b_src = accept ? B_in : b_hold_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_ISSUE_LO;
      end
      S_ISSUE_LO: begin
        if (out_ready) state_d = S_ISSUE_MID;
      end
      S_ISSUE_MID: begin
        if (out_ready) state_d = S_ISSUE_HI;
      end
      S_ISSUE_HI: begin
        if (out_ready) state_d = in_valid ? S_ISSUE_LO : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values for the state being entered. While an issue state
  // stalls, state_d and the holding registers are unchanged, so the
  // registered outputs hold.
  always_comb begin
    out_valid_d = 1'b0;
    a_out_d     = '0;
    b_out_d     = '0;
    tag_d       = '0;
    last_d      = 1'b0;
    case (state_d)
      S_ISSUE_LO: begin
        out_valid_d = 1'b1;
        a_out_d     = lo_half(a_src);
        b_out_d     = lo_half(b_src);
        tag_d       = TAG_W'(0);
      end
      S_ISSUE_MID: begin
        out_valid_d = 1'b1;
        a_out_d     = lo_half(a_src) ^ hi_half(a_src);
        b_out_d     = lo_half(b_src) ^ hi_half(b_src);
        tag_d       = TAG_W'(1);
      end
      S_ISSUE_HI: begin
        out_valid_d = 1'b1;
        a_out_d     = hi_half(a_src);
        b_out_d     = hi_half(b_src);
        tag_d       = TAG_W'(2);
        last_d      = 1'b1;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      tag_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      tag_q       <= tag_d;
      last_q      <= last_d;
    end
  end

  // Operand holding registers, written only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else if (accept) begin
      a_hold_q <= A_in;
      b_hold_q <= B_in;
    end
  end

  // Completed-pair counter, bumped when the high slot is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (issue_done) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign A_out     = a_out_q;
  assign B_out     = b_out_q;
  assign out_tag   = tag_q;
  assign out_last  = last_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_split_issue_13bit.sv
`timescale 1ns/1ps
// Testbench for split_issue_13bit: table vectors, backpressure, back-to-back
// with mid-transaction reset, random traffic against a queue model, and
// op_count wrap.
module tb_split_issue_13bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] A_in, B_in;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  A_out, B_out;
  logic [1:0]  out_tag;
  logic        out_last;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  split_issue_13bit #(.N(14), .LO_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_in      (A_in),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .op_count  (op_count)
  );

  typedef struct {
    int         tag;
    logic [6:0] a;
    logic [6:0] b;
  } exp_t;

  typedef struct {
    logic [12:0] a, b;
    logic [6:0]  la, lb, ma, mb, ha, hb;
  } vec_t;

  exp_t        q[$];
  logic [15:0] m_count;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] lo7(input logic [12:0] x);
    return 7'(x % 13'd128);
  endfunction

  function automatic logic [6:0] hi7(input logic [12:0] x);
    return 7'(x / 13'd128);
  endfunction

  // One accepted operand pair becomes three expected issues.
  task automatic push_op(input logic [12:0] a, input logic [12:0] b);
    exp_t e;
    e.tag = 0; e.a = lo7(a);           e.b = lo7(b);           q.push_back(e);
    e.tag = 1; e.a = lo7(a) ^ hi7(a);  e.b = lo7(b) ^ hi7(b);  q.push_back(e);
    e.tag = 2; e.a = hi7(a);           e.b = hi7(b);           q.push_back(e);
  endtask

  // Compare the DUT against the model, then apply the handshakes that the
  // coming clock edge will perform.
  task automatic monitor();
    exp_t e;
    logic exp_rdy;
    exp_rdy = (q.size() == 0) || ((q.size() == 1) && out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("op_count", 32'(op_count), 32'(m_count));
    if (q.size() != 0) begin
      e = q[0];
      chk("out_tag", 32'(out_tag), 32'(e.tag));
      chk("A_out", 32'(A_out), 32'(e.a));
      chk("B_out", 32'(B_out), 32'(e.b));
      chk("out_last", 32'(out_last), 32'(e.tag == 2));
      if (out_ready) begin
        void'(q.pop_front());
        if (e.tag == 2) m_count = m_count + 16'd1;
      end
    end
    if (in_valid && exp_rdy) push_op(A_in, B_in);
  endtask

  task automatic cycle(input logic iv, input logic [12:0] a, input logic [12:0] b,
                       input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    A_in      = a;
    B_in      = b;
    out_ready = ordy;
    #1;
    monitor();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 expected earlier");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[4];
    logic [15:0] base;
    int          nvalid, ntag1;
    bit          gap, started, found;

    vecs[0] = '{13'h1FFF, 13'h0001, 7'h7F, 7'h01, 7'h40, 7'h01, 7'h3F, 7'h00};
    vecs[1] = '{13'h0A5B, 13'h1234, 7'h5B, 7'h34, 7'h4F, 7'h10, 7'h14, 7'h24};
    vecs[2] = '{13'h0000, 13'h1F80, 7'h00, 7'h00, 7'h00, 7'h3F, 7'h00, 7'h3F};
    vecs[3] = '{13'h0080, 13'h007F, 7'h00, 7'h7F, 7'h01, 7'h7F, 7'h01, 7'h00};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A_in = '0; B_in = '0;
    m_count = '0;

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    q.delete(); m_count = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 13'h1555, 13'h0AAA, 1'b1);
      chk("idle_A_out", 32'(A_out), 0);
      chk("idle_tag", 32'(out_tag), 0);
      chk("idle_last", 32'(out_last), 0);
    end

    // Table-driven split vectors, out_ready held high.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      chk("vec_lo_valid", 32'(out_valid), 1);
      chk("vec_lo_tag", 32'(out_tag), 0);
      chk("vec_lo_A", 32'(A_out), 32'(vecs[i].la));
      chk("vec_lo_B", 32'(B_out), 32'(vecs[i].lb));
      cycle(1'b0, '0, '0, 1'b1);
      chk("vec_mid_tag", 32'(out_tag), 1);
      chk("vec_mid_A", 32'(A_out), 32'(vecs[i].ma));
      chk("vec_mid_B", 32'(B_out), 32'(vecs[i].mb));
      cycle(1'b0, '0, '0, 1'b1);
      chk("vec_hi_tag", 32'(out_tag), 2);
      chk("vec_hi_last", 32'(out_last), 1);
      chk("vec_hi_A", 32'(A_out), 32'(vecs[i].ha));
      chk("vec_hi_B", 32'(B_out), 32'(vecs[i].hb));
      cycle(1'b0, '0, '0, 1'b1);
      chk("vec_done_valid", 32'(out_valid), 0);
      chk("vec_op_count", 32'(op_count), 32'(i + 1));
    end

    // Backpressure: five stalled cycles in each issue state, with noise on
    // the inputs that must be ignored.
    cycle(1'b1, 13'h1A2B, 13'h0C3D, 1'b0);
    for (int t = 0; t < 3; t++) begin
      for (int s = 0; s < 5; s++) begin
        cycle(1'b1, 13'($urandom), 13'($urandom), 1'b0);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_tag", 32'(out_tag), 32'(t));
      end
      cycle(1'b0, '0, '0, 1'b1);
    end
    cycle(1'b0, '0, '0, 1'b1);

    // Back-to-back: four pairs, twelve contiguous valid cycles.
    base = m_count; nvalid = 0; gap = 1'b0; started = 1'b0;
    for (int c = 0; c < 14; c++) begin
      cycle(c < 12, 13'($urandom), 13'($urandom), 1'b1);
      if (out_valid) begin
        nvalid++;
        if (gap) chk("b2b_no_gap", 1, 0);
        started = 1'b1;
      end else if (started) begin
        gap = 1'b1;
      end
    end
    chk("b2b_valid_cycles", 32'(nvalid), 12);
    chk("b2b_op_count", 32'(op_count), 32'(base + 16'd4));

    // Back-to-back again, reset while the second pair is in its middle slot.
    ntag1 = 0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle(1'b1, 13'($urandom), 13'($urandom), 1'b1);
      if (out_valid && out_tag == 2'd1) ntag1++;
      if (ntag1 == 2) found = 1'b1;
    end
    chk("rstmid_reached", 32'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete(); m_count = '0;
    chk("rstmid_out_valid", 32'(out_valid), 0);
    chk("rstmid_op_count", 32'(op_count), 0);
    chk("rstmid_in_ready", 32'(in_ready), 1);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, '0, 1'b1);
      chk("rstmid_no_issue", 32'(out_valid), 0);
    end

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom_range(0, 1)), 13'($urandom), 13'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 8; c++) cycle(1'b0, '0, '0, 1'b1);

    // Counter wrap from 0xFFFF.
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    m_count = 16'hFFFF;
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, 13'h0F0F, 13'h10F0, 1'b1);
    for (int c = 0; c < 3; c++) cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    chk("wrap_op_count", 32'(op_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/split_issue_13bit.md
# split_issue_13bit

Sequential operand splitter and issuer for the 13-bit GF(2) Karatsuba stage; the front-end counterpart of the 13-bit overlap-add combiner. Accepts one pair of 13-bit polynomial operands per transaction, splits each at bit 7 into a 7-bit low half and a 6-bit high half, and issues three 7-bit sub-operand pairs, one per handshake: low, middle and high. Downstream, a shared 7x7 GF(2) multiplier computes the three partial products that the combiner places at offsets 0, 7 and 14.

## Interface
Parameters:
- N, 14: operand width is N-1 = 13.
- LO_W, 7: low-half width, which is also the sub-operand width. The high half is N-1-LO_W = 6 bits.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  splitter can accept an operand pair.
- A_in  in  13  operand A; bit i is the coefficient of x^i.
- B_in  in  13  operand B.
- out_valid  out  1  sub-operand pair valid.
- out_ready  in  1  multiplier accepts the pair.
- A_out  out  7  sub-operand A.
- B_out  out  7  sub-operand B.
- out_tag  out  2  slot of the pair: 0 = low, 1 = middle, 2 = high. Value 3 is never driven.
- out_last  out  1  high for the tag-2 pair only.
- op_count  out  16  number of fully issued operand pairs; wraps modulo 2^16.

## Operation
- Capture: on in_valid && in_ready, register A_in and B_in into holding registers.
- Split per operand X:
  - X_lo = X[6:0].
  - X_hi = {1'b0, X[12:7]}.
  - X_mid = X_lo ^ X_hi (GF(2) sum, no carries).
- Issue order is fixed: tag 0 (A_lo, B_lo), then tag 1 (A_mid, B_mid), then tag 2 (A_hi, B_hi).
- FSM states are IDLE, ISSUE_LO, ISSUE_MID and ISSUE_HI.
  - IDLE: in_ready = 1. On accept, go to ISSUE_LO.
  - ISSUE_LO: on out_ready, go to ISSUE_MID.
  - ISSUE_MID: on out_ready, go to ISSUE_HI.
  - ISSUE_HI: on out_ready, op_count increments. If in_valid is also high in the same cycle, the new operands are captured and the FSM goes to ISSUE_LO. Otherwise it goes to IDLE.
  - In every ISSUE state, the FSM holds while out_ready = 0.
- in_ready = (state == IDLE) || (state == ISSUE_HI && out_ready). This is combinational from registered state and out_ready.
- out_valid, A_out, B_out, out_tag and out_last are registered. They are loaded for the next state on each transition.
- Output stability: while out_valid = 1 and out_ready = 0, every output holds its value.
- Holding registers change only on accept. Input changes while not ready are ignored.
- Reset mid-transaction: the in-flight operands are discarded with no partial completion. op_count is not incremented for that operand pair.

## Timing
- Reset values:
  - state = IDLE.
  - out_valid = 0, A_out = 0, B_out = 0, out_tag = 0, out_last = 0.
  - op_count = 0.
  - Holding registers = 0.
  - in_ready reads 1 whenever the FSM is in IDLE, including during reset.
- Latency: accept at edge k gives out_valid = 1 with tag 0 after edge k.
- With out_ready held high, tags 0, 1 and 2 occupy three consecutive cycles.
- Throughput: one operand pair per 3 cycles with no bubble when the next operands are presented during the ISSUE_HI handoff.
- op_count updates on the edge where the tag-2 pair is accepted. It wraps from 0xFFFF to 0x0000.
- When the FSM returns to IDLE, out_valid drops on the edge following the tag-2 handoff.

## Test plan
- Reset: assert rst_n = 0 asynchronously mid-cycle.
  - During reset: out_valid = 0, op_count = 0, in_ready = 1.
  - After release, with no in_valid: outputs stay 0.
- Basic split: A = 13'h1FFF, B = 13'h0001, out_ready = 1.
  - Tag 0: A = 7'h7F, B = 7'h01.
  - Tag 1: A = 7'h40, B = 7'h01.
  - Tag 2: A = 7'h3F, B = 7'h00, out_last = 1.
  - op_count = 1.
- Mixed bits: A = 13'h0A5B, B = 13'h1234.
  - Tag 0: 7'h5B / 7'h34.
  - Tag 1: 7'h4F / 7'h10.
  - Tag 2: 7'h14 / 7'h24.
- Backpressure: out_ready = 0 for 5 cycles in each ISSUE state. Outputs stay stable, in_ready = 0, and tag order is preserved.
- Back-to-back: 4 operand pairs with in_valid and out_ready always high. Twelve consecutive valid cycles with no gap, and op_count = 4. During this run, reassert rst_n = 0 in ISSUE_MID of the second pair. The FSM returns to IDLE with op_count = 0, and no tag 2 is issued for that pair.
- Wrap: preload 65535 transactions (or force op_count = 16'hFFFF), then complete one more. op_count = 16'h0000.
